ifft4_seq: RTL and testbench

//  Sequential 4-point radix-2 DIT inverse FFT; the return path paired with the forward fft4 block.

---
 rtl/ifft4_pkg.sv | 20 ++
 rtl/ifft4_bfly.sv | 39 +++
 rtl/ifft4_seq.sv | 147 ++++++++++++++
 tb/tb_ifft4_seq.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft4_pkg.sv
// rtl/ifft4_pkg.sv - shared types for the 4-point sequential inverse FFT
package ifft4_pkg;

    localparam int IFFT4_DW = 16;

    typedef struct packed {
        logic signed [IFFT4_DW-1:0] re;
        logic signed [IFFT4_DW-1:0] im;
    } cplx_t;

    typedef enum logic [2:0] {
        IDLE,
        S1A,
        S1B,
        S2A,
        S2B,
        DONE
    } ifft4_state_e;

endpackage

// File: rtl/ifft4_bfly.sv
// rtl/ifft4_bfly.sv - radix-2 butterfly with optional +j rotation; IFFT4_SCALE_EN halves each output
module ifft4_bfly
    import ifft4_pkg::*;
(
    input  cplx_t p,
    input  cplx_t q,
    input  logic  rot_j,
    output cplx_t sum,
    output cplx_t diff
);

    localparam int W = IFFT4_DW;
`ifdef IFFT4_SCALE_EN
    localparam int SH = 1;
`else
    localparam int SH = 0;
`endif

    logic signed [W:0] qr, qi, sr, si, dr, di;

    // j*q = (-q.im, q.re): swap and negate only, at W+1 bits so -min cannot overflow
    always_comb begin
        if (rot_j) begin
            qr = -{q.im[W-1], q.im};
            qi = {q.re[W-1], q.re};
        end else begin
            qr = {q.re[W-1], q.re};
            qi = {q.im[W-1], q.im};
        end
        sr = {p.re[W-1], p.re} + qr;
        si = {p.im[W-1], p.im} + qi;
        dr = {p.re[W-1], p.re} - qr;
        di = {p.im[W-1], p.im} - qi;
    end

    assign sum  = {W'(sr >>> SH), W'(si >>> SH)};
    assign diff = {W'(dr >>> SH), W'(di >>> SH)};

endmodule

// File: rtl/ifft4_seq.sv
// rtl/ifft4_seq.sv - sequential 4-point radix-2 DIT inverse FFT, one shared butterfly; IFFT4_SCALE_EN selects 1/4 gain
module ifft4_seq
    import ifft4_pkg::*;
#(
    parameter int DW = IFFT4_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x0_re,
    input  logic [DW-1:0] x0_im,
    input  logic [DW-1:0] x1_re,
    input  logic [DW-1:0] x1_im,
    input  logic [DW-1:0] x2_re,
    input  logic [DW-1:0] x2_im,
    input  logic [DW-1:0] x3_re,
    input  logic [DW-1:0] x3_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_re,
    output logic [DW-1:0] y0_im,
    output logic [DW-1:0] y1_re,
    output logic [DW-1:0] y1_im,
    output logic [DW-1:0] y2_re,
    output logic [DW-1:0] y2_im,
    output logic [DW-1:0] y3_re,
    output logic [DW-1:0] y3_im
);

    ifft4_state_e state, state_nxt;

    cplx_t x0, x1, x2, x3;
    cplx_t a, b, c, d;
    cplx_t y0, y1, y2, y3;
    cplx_t bp, bq, bs, bd;
    logic  rot;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = S1A;
            S1A:     state_nxt = S1B;
            S1B:     state_nxt = S2A;
            S2A:     state_nxt = S2B;
            S2B:     state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bp  = x0;
        bq  = x2;
        rot = 1'b0;
        case (state)
            S1B: begin
                bp = x1;
                bq = x3;
            end
            S2A: begin
                bp = a;
                bq = c;
            end
            S2B: begin
                bp  = b;
                bq  = d;
                rot = 1'b1;
            end
            default: ;
        endcase
    end

    ifft4_bfly u_bfly (
        .p     (bp),
        .q     (bq),
        .rot_j (rot),
        .sum   (bs),
        .diff  (bd)
    );

    // y0/y2 are parked in a/c during S2A so all outputs update together on leaving S2B
    always_ff @(posedge clk) begin
        if (rst) begin
            x0 <= '0;
            x1 <= '0;
            x2 <= '0;
            x3 <= '0;
            a  <= '0;
            b  <= '0;
            c  <= '0;
            d  <= '0;
            y0 <= '0;
            y1 <= '0;
            y2 <= '0;
            y3 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0 <= {x0_re, x0_im};
                        x1 <= {x1_re, x1_im};
                        x2 <= {x2_re, x2_im};
                        x3 <= {x3_re, x3_im};
                    end
                end
                S1A: begin
                    a <= bs;
                    b <= bd;
                end
                S1B: begin
                    c <= bs;
                    d <= bd;
                end
                S2A: begin
                    a <= bs;
                    c <= bd;
                end
                S2B: begin
                    y0 <= a;
                    y2 <= c;
                    y1 <= bs;
                    y3 <= bd;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign y0_re = y0.re;
    assign y0_im = y0.im;
    assign y1_re = y1.re;
    assign y1_im = y1.im;
    assign y2_re = y2.re;
    assign y2_im = y2.im;
    assign y3_re = y3.re;
    assign y3_im = y3.im;

endmodule

// File: tb/tb_ifft4_seq.sv
// tb/tb_ifft4_seq.sv - randomized self-checking bench for ifft4_seq against a DFT reference model
module tb_ifft4_seq;

    typedef logic [7:0][15:0] frame_t;

    logic clk = 1'b0;
    logic rst, in_valid, in_ready, out_valid, out_ready;
    frame_t xin, dut_y;
    logic [15:0] x0_re, x0_im, x1_re, x1_im, x2_re, x2_im, x3_re, x3_im;
    logic [15:0] y0_re, y0_im, y1_re, y1_im, y2_re, y2_im, y3_re, y3_im;

    assign {x3_im, x3_re, x2_im, x2_re, x1_im, x1_re, x0_im, x0_re} = xin;
    assign dut_y = {y3_im, y3_re, y2_im, y2_re, y1_im, y1_re, y0_im, y0_re};

    always #5 clk = ~clk;

    ifft4_seq #(.DW(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x0_re     (x0_re),
        .x0_im     (x0_im),
        .x1_re     (x1_re),
        .x1_im     (x1_im),
        .x2_re     (x2_re),
        .x2_im     (x2_im),
        .x3_re     (x3_re),
        .x3_im     (x3_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0_re     (y0_re),
        .y0_im     (y0_im),
        .y1_re     (y1_re),
        .y1_im     (y1_im),
        .y2_re     (y2_re),
        .y2_im     (y2_im),
        .y3_re     (y3_re),
        .y3_im     (y3_im)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int sx(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int fl(input int v);
`ifdef IFFT4_SCALE_EN
        return v >>> 1;
`else
        return v;
`endif
    endfunction

    // Unscaled: direct DFT y_k = sum x_n * j^(nk), wrapped to 16 bits.
    // Scaled: each radix-2 stage halves with floor.
    function automatic frame_t model(input frame_t x);
        int xr[4], xi[4], yr[4], yi[4];
        int ar, ai, br, bi, cr, ci, dr, di, m;
        frame_t y;
        for (int n = 0; n < 4; n++) begin
            xr[n] = sx(x[2*n]);
            xi[n] = sx(x[2*n+1]);
        end
`ifdef IFFT4_SCALE_EN
        ar = fl(xr[0] + xr[2]);  ai = fl(xi[0] + xi[2]);
        br = fl(xr[0] - xr[2]);  bi = fl(xi[0] - xi[2]);
        cr = fl(xr[1] + xr[3]);  ci = fl(xi[1] + xi[3]);
        dr = fl(xr[1] - xr[3]);  di = fl(xi[1] - xi[3]);
        yr[0] = fl(ar + cr);  yi[0] = fl(ai + ci);
        yr[2] = fl(ar - cr);  yi[2] = fl(ai - ci);
        yr[1] = fl(br - di);  yi[1] = fl(bi + dr);
        yr[3] = fl(br + di);  yi[3] = fl(bi - dr);
        m = 0;
`else
        ar = 0; ai = 0; br = 0; bi = 0; cr = 0; ci = 0; dr = 0; di = 0;
        for (int k = 0; k < 4; k++) begin
            yr[k] = 0;
            yi[k] = 0;
            for (int n = 0; n < 4; n++) begin
                m = (n * k) % 4;
                case (m)
                    0: begin yr[k] += xr[n]; yi[k] += xi[n]; end
                    1: begin yr[k] -= xi[n]; yi[k] += xr[n]; end
                    2: begin yr[k] -= xr[n]; yi[k] -= xi[n]; end
                    default: begin yr[k] += xi[n]; yi[k] -= xr[n]; end
                endcase
            end
        end
`endif
        for (int k = 0; k < 4; k++) begin
            y[2*k]   = 16'(yr[k]);
            y[2*k+1] = 16'(yi[k]);
        end
        return y;
    endfunction

    function automatic frame_t rnd_frame();
        frame_t f;
        for (int i = 0; i < 8; i++) begin
            case ($urandom_range(0, 3))
                0: f[i] = 16'h7FFF;
                1: f[i] = 16'h8000;
                default: f[i] = 16'($urandom);
            endcase
        end
        return f;
    endfunction

    frame_t exp_q[$];
    int     cap_q[$];
    int     cyc = 0;
    bit     seen = 0;
    bit     b2b = 0;
    bit     last_hs_ok = 0;
    int     last_hs = 0;
    int     b2b_hs = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                exp_q.delete();
                cap_q.delete();
                seen = 0;
                last_hs_ok = 0;
            end else begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 1, 0);
                    end else begin
                        chk("y_frame", dut_y, exp_q[0]);
                        if (!seen) begin
                            chk("latency", cyc - cap_q[0], 5);
                            seen = 1;
                        end
                        if (out_ready) begin
                            void'(exp_q.pop_front());
                            void'(cap_q.pop_front());
                            seen = 0;
                        end
                    end
                end
                if (in_valid && in_ready) begin
                    if (b2b) begin
                        b2b_hs++;
                        if (last_hs_ok) chk("b2b_spacing", cyc - last_hs, 6);
                    end
                    last_hs = cyc;
                    last_hs_ok = 1;
                    exp_q.push_back(model(xin));
                    cap_q.push_back(cyc);
                end
                if (!b2b) last_hs_ok = 0;
            end
        end
    end

    task automatic send(input frame_t f);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        xin = f;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        xin = rnd_frame();
    endtask

    task automatic wait_out();
        bit ok;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("out_timeout", 0, 1);
    endtask

    task automatic release_out();
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f, e, hold;
        int hold_cycles;
        bit pre;

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        xin = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_y", dut_y, 0);

        // impulse plus backpressure
        f = '0;
        f[0] = 16'd4;
        e = '0;
`ifdef IFFT4_SCALE_EN
        e[0] = 16'd1; e[2] = 16'd1; e[4] = 16'd1; e[6] = 16'd1;
`else
        e[0] = 16'd4; e[2] = 16'd4; e[4] = 16'd4; e[6] = 16'd4;
`endif
        chk("model_impulse", model(f), e);
        send(f);
        wait_out();
        chk("impulse", dut_y, e);
        hold = dut_y;
        repeat (3) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_y_stable", dut_y, hold);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        // single bin
        f = '0;
        f[2] = 16'd1;
        e = '0;
`ifndef IFFT4_SCALE_EN
        e[0] = 16'd1; e[3] = 16'd1; e[4] = 16'hFFFF; e[7] = 16'hFFFF;
`endif
        chk("model_single_bin", model(f), e);
        send(f);
        wait_out();
        chk("single_bin", dut_y, e);
        release_out();

        // overflow
        f = '0;
        f[0] = 16'h7FFF;
        f[4] = 16'h7FFF;
        e = '0;
`ifdef IFFT4_SCALE_EN
        e[0] = 16'h3FFF; e[4] = 16'h3FFF;
`else
        e[0] = 16'hFFFE; e[4] = 16'hFFFE;
`endif
        chk("model_overflow", model(f), e);
        send(f);
        wait_out();
        chk("overflow", dut_y, e);
        release_out();

        // reset while in S2A
        send(rnd_frame());
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_y_cleared", dut_y, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(rnd_frame());
        wait_out();
        release_out();

        // random frames with random backpressure
        for (int n = 0; n < 30; n++) begin
            pre = 1'($urandom_range(0, 1));
            out_ready = pre;
            send(rnd_frame());
            wait_out();
            if (!pre) begin
                hold_cycles = $urandom_range(0, 3);
                repeat (hold_cycles) @(posedge clk);
                release_out();
            end else begin
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        end

        // back-to-back
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        b2b = 1'b1;
        b2b_hs = 0;
        in_valid = 1'b1;
        xin = rnd_frame();
        repeat (64) begin
            @(posedge clk);
            #1 xin = rnd_frame();
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        b2b = 1'b0;
        out_ready = 1'b0;
        chk("b2b_frames", b2b_hs, 11);

        @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
